rptr_empty: RTL and testbench
=============================

# rptr_empty

Read-side pointer and empty-flag generator for the asynchronous FIFO, in the read clock domain directly downstream of the write-to-read pointer synchronizer. Consumes the synchronized Gray write pointer and the read request. Produces:
- the binary read address for the dual-port memory;
- the Gray read pointer handed to the read-to-write synchronizer;
- registered empty, almost-empty, occupancy and underflow indications.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4; AW = $clog2(DEPTH), pointer width PW = AW+1
- AE_THRESH, 2, almost_empty asserts when occupancy ≤ AE_THRESH; range 0..DEPTH-1

Ports:
- r_clk  input  1  read clock; the only clock
- rst_n  input  1  reset, asynchronous assert, active-low
- r_en  input  1  read request from the consumer
- rsync_ptr2  input  PW  Gray write pointer, already synchronized to r_clk
- rptr  output  PW  Gray read pointer, registered, to the read-to-write synchronizer
- raddr  output  AW  binary read address, equal to rbin[AW-1:0]
- empty  output  1  FIFO empty, registered
- almost_empty  output  1  occupancy ≤ AE_THRESH, registered
- rd_count  output  PW  occupancy seen from the read side, 0..DEPTH, registered
- underflow  output  1  one-cycle pulse when a read is requested while empty

## Operation
- Internal state:
  - rbin: PW-bit binary read pointer.
  - rptr: Gray form of rbin.
- Read acceptance:
  - rd_ok = r_en & ~empty.
  - rbin_next = rbin + rd_ok, modulo 2^PW.
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
- Empty flag: empty_next = (rgray_next == rsync_ptr2). The comparison is on full PW bits, wrap bit included.
- Occupancy:
  - wbin_s = gray-to-binary(rsync_ptr2).
  - count_next = (wbin_s − rbin_next) mod 2^PW, which always lies in 0..DEPTH.
  - almost_empty_next = (count_next ≤ AE_THRESH).
- Underflow:
  - underflow_next = r_en & empty.
  - A rejected read leaves rbin, rptr and raddr unchanged.
- Wrap-around: rbin rolls from 2^PW−1 to 0. raddr wraps every DEPTH reads. The Gray wrap bit toggles every DEPTH reads.
- Simultaneous read and write arrival in one cycle: count_next and empty_next use both the new rbin_next and the current rsync_ptr2 in the same cycle.
- Pessimism is inherent because of synchronizer lag: empty may stay asserted while data is already present; it never deasserts falsely.

## Timing
- All outputs are registered on posedge r_clk.
- Reset values: rbin=0, rptr=0, raddr=0, empty=1, almost_empty=1, rd_count=0, underflow=0.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first read can be accepted on the second rising edge after rst_n deasserts, once empty has updated.
- Read latency:
  - A read accepted at edge N advances raddr, rptr and the flags at edge N.
  - Memory data for the new raddr is the memory's concern.
- Write visibility: a change on rsync_ptr2 is reflected in empty, rd_count and almost_empty one r_clk edge later. End to end from the write pointer this is 2 synchronizer edges + 1 edge.
- The last read deasserts nothing late: empty asserts at the same edge that consumes the final entry.

## Configuration
- FIFO_RD_COUNT_EN:
  - Defined: the gray-to-binary conversion, rd_count and almost_empty are implemented as described above.
  - Undefined: the conversion logic is omitted, rd_count is tied to 0, and almost_empty is driven equal to empty.
- empty, rptr, raddr and underflow are identical in both builds.

## Structure
- Shared package fifo_pkg holds:
  - the pointer-width helper (AW/PW derivation from DEPTH);
  - the ptr_t/addr_t style typedefs parameterized by width;
  - the bin2gray/gray2bin functions, shared with the write-side full logic.
- Sub-module gray2bin (parameter W) performs the XOR-prefix conversion of rsync_ptr2. It is instantiated only under FIFO_RD_COUNT_EN.

## Test plan
All scenarios use DEPTH=16, AE_THRESH=2 and FIFO_RD_COUNT_EN defined unless stated.
1. Reset and idle:
   - Hold rst_n=0, pulse r_en → rptr=0, raddr=0, empty=1, almost_empty=1, rd_count=0, underflow=0.
   - Release reset with rsync_ptr2=0 → values hold.
2. Fill then drain:
   - Set rsync_ptr2=5'h02 (binary 3) → next edge empty=0, rd_count=3, almost_empty=0.
   - Three back-to-back reads → raddr 1, 2, 3 after each edge, rd_count 2, 1, 0.
   - almost_empty=1 from rd_count=2; empty=1 on the third read's edge.
3. Underflow: r_en=1 for 2 cycles while empty → underflow=1 for each of those cycles, rptr and raddr unchanged, no false empty deassert.
4. Full occupancy and wrap:
   - rsync_ptr2=5'h18 (binary 16) with rbin=0 → rd_count=16.
   - 16 reads → raddr wraps 15→0, rptr=5'h18, empty=1.
   - Continue to 32 reads total → rptr returns to 0.
5. Reset mid-drain: assert rst_n=0 at rd_count=7 between clock edges → all outputs reach reset values immediately, without waiting for a clock edge.
6. Macro undefined: repeat scenario 2 → rd_count stays 0, almost_empty tracks empty exactly, empty/raddr/rptr sequence identical to scenario 2.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared async-FIFO helpers: pointer widths, pointer/address
//               typedefs and Gray/binary conversion functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int c_DEF_DEPTH = 16;

    // Address width for a power-of-two depth; the pointer carries one extra wrap bit.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int c_DEF_AW = $clog2(c_DEF_DEPTH);
    localparam int c_DEF_PW = c_DEF_AW + 1;

    typedef logic [c_DEF_PW-1:0] ptr_t;
    typedef logic [c_DEF_AW-1:0] addr_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 1; i < 32; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin.sv
// ============================================================================
// Module      : gray2bin
// Description : Combinational Gray-to-binary conversion (XOR prefix from MSB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

`default_nettype wire

// File: rtl/rptr_empty.sv
// ============================================================================
// Module      : rptr_empty
// Description : Read-side pointer, empty/almost-empty, occupancy and underflow
//               generation for the async FIFO. FIFO_RD_COUNT_EN enables
//               rd_count and true almost_empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rptr_empty
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AE_THRESH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = AW + 1
) (
    input  logic          r_clk,
    input  logic          rst_n,
    input  logic          r_en,
    input  logic [PW-1:0] rsync_ptr2,
    output logic [PW-1:0] rptr,
    output logic [AW-1:0] raddr,
    output logic          empty,
    output logic          almost_empty,
    output logic [PW-1:0] rd_count,
    output logic          underflow
);

    logic [PW-1:0] r_bin;
    logic          w_rd_ok;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [31:0]   w_gray_full;
    logic          w_empty_next;

    assign w_rd_ok      = r_en & ~empty;
    assign w_bin_next   = r_bin + {{(PW-1){1'b0}}, w_rd_ok};
    assign w_gray_full  = bin2gray({{(32-PW){1'b0}}, w_bin_next});
    assign w_gray_next  = w_gray_full[PW-1:0];
    // Full-width compare: the wrap bit separates "empty" from "full".
    assign w_empty_next = (w_gray_next == rsync_ptr2);

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin     <= '0;
            rptr      <= '0;
            empty     <= 1'b1;
            underflow <= 1'b0;
        end else begin
            r_bin     <= w_bin_next;
            rptr      <= w_gray_next;
            empty     <= w_empty_next;
            underflow <= r_en & empty;
        end
    end

    assign raddr = r_bin[AW-1:0];

`ifdef FIFO_RD_COUNT_EN
    localparam logic [PW-1:0] c_AE_THRESH = PW'(AE_THRESH);

    logic [PW-1:0] w_wbin_s;
    logic [PW-1:0] w_count_next;
    logic          r_almost_empty;
    logic [PW-1:0] r_rd_count;

    gray2bin #(
        .W (PW)
    ) u_gray2bin (
        .gray (rsync_ptr2),
        .bin  (w_wbin_s)
    );

    assign w_count_next = w_wbin_s - w_bin_next;

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count     <= '0;
            r_almost_empty <= 1'b1;
        end else begin
            r_rd_count     <= w_count_next;
            r_almost_empty <= (w_count_next <= c_AE_THRESH);
        end
    end

    assign rd_count     = r_rd_count;
    assign almost_empty = r_almost_empty;
`else
    assign rd_count     = '0;
    assign almost_empty = empty;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rptr_empty.sv
// ============================================================================
// Module      : tb_rptr_empty
// Description : Self-checking bench for rptr_empty with an occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rptr_empty;

    localparam int DEPTH = 16;
    localparam int AE    = 2;
    localparam int AW    = 4;
    localparam int PW    = 5;

    logic          r_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r_en  = 1'b0;
    logic [PW-1:0] rsync_ptr2;
    logic [PW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_count;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    // Writer side expressed as an unbounded count of entries written.
    int wbin = 0;

    // Model: total reads accepted, occupancy, flags.
    int m_rd    = 0;
    int m_count = 0;
    bit m_empty = 1'b1;
    bit m_uf    = 1'b0;

    function automatic int gray_of(input int v);
        int b;
        b = v % 32;
        return b ^ (b >> 1);
    endfunction

    assign rsync_ptr2 = PW'(gray_of(wbin));

    rptr_empty #(
        .DEPTH     (DEPTH),
        .AE_THRESH (AE)
    ) dut (
        .r_clk        (r_clk),
        .rst_n        (rst_n),
        .r_en         (r_en),
        .rsync_ptr2   (rsync_ptr2),
        .rptr         (rptr),
        .raddr        (raddr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
        .underflow    (underflow)
    );

    always #5 r_clk = ~r_clk;

    function automatic int exp_count(input int c);
`ifdef FIFO_RD_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_ae(input int c, input bit e);
`ifdef FIFO_RD_COUNT_EN
        return (c <= AE) ? 1 : 0;
`else
        return e ? 1 : 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd    = 0;
            m_count = 0;
            m_empty = 1'b1;
            m_uf    = 1'b0;
        end else begin
            m_uf    = r_en && m_empty;
            if (r_en && !m_empty) m_rd = m_rd + 1;
            m_count = wbin - m_rd;
            m_empty = (m_count == 0);
        end
    end

    always @(negedge r_clk) begin
        chk("rptr", int'(rptr), gray_of(m_rd));
        chk("raddr", int'(raddr), m_rd % DEPTH);
        chk("empty", int'(empty), int'(m_empty));
        chk("rd_count", int'(rd_count), exp_count(m_count));
        chk("almost_empty", int'(almost_empty), exp_ae(m_count, m_empty));
        chk("underflow", int'(underflow), int'(m_uf));
    end

    task automatic do_reset();
        rst_n = 1'b0;
        r_en  = 1'b0;
        wbin  = 0;
        @(negedge r_clk);
        @(negedge r_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset and idle, pulsing r_en while held in reset.
        @(negedge r_clk);
        r_en = 1'b1;
        @(negedge r_clk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_rptr", int'(rptr), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk("rst_ae", int'(almost_empty), 1);
        r_en  = 1'b0;
        rst_n = 1'b1;
        @(negedge r_clk);
        chk("idle_empty", int'(empty), 1);
        chk("idle_raddr", int'(raddr), 0);

        // Fill three, drain three, then underflow twice.
        wbin = 3;
        @(negedge r_clk);
        chk("fill_empty", int'(empty), 0);
        chk("fill_count", int'(rd_count), exp_count(3));
        chk("fill_ae", int'(almost_empty), exp_ae(3, 1'b0));
        r_en = 1'b1;
        @(negedge r_clk);
        chk("rd1_raddr", int'(raddr), 1);
        chk("rd1_count", int'(rd_count), exp_count(2));
        chk("rd1_ae", int'(almost_empty), exp_ae(2, 1'b0));
        chk("rd1_empty", int'(empty), 0);
        @(negedge r_clk);
        chk("rd2_raddr", int'(raddr), 2);
        chk("rd2_count", int'(rd_count), exp_count(1));
        @(negedge r_clk);
        chk("rd3_raddr", int'(raddr), 3);
        chk("rd3_count", int'(rd_count), exp_count(0));
        chk("rd3_empty", int'(empty), 1);
        @(negedge r_clk);
        chk("uf1", int'(underflow), 1);
        chk("uf1_raddr", int'(raddr), 3);
        chk("uf1_rptr", int'(rptr), 5'h02);
        @(negedge r_clk);
        chk("uf2", int'(underflow), 1);
        chk("uf2_empty", int'(empty), 1);
        r_en = 1'b0;
        @(negedge r_clk);
        chk("uf_clear", int'(underflow), 0);

        // Full occupancy and pointer wrap.
        do_reset();
        @(negedge r_clk);
        wbin = 16;
        @(negedge r_clk);
        chk("full_count", int'(rd_count), exp_count(16));
        chk("full_rsync", int'(rsync_ptr2), 5'h18);
        r_en = 1'b1;
        repeat (16) @(negedge r_clk);
        chk("wrap_raddr", int'(raddr), 0);
        chk("wrap_rptr", int'(rptr), 5'h18);
        chk("wrap_empty", int'(empty), 1);
        wbin = 32;
        repeat (18) @(negedge r_clk);
        r_en = 1'b0;
        chk("wrap2_rptr", int'(rptr), 0);
        chk("wrap2_empty", int'(empty), 1);

        // Asynchronous reset mid-drain.
        do_reset();
        @(negedge r_clk);
        wbin = 10;
        @(negedge r_clk);
        r_en = 1'b1;
        repeat (3) @(negedge r_clk);
        chk("mid_count", int'(rd_count), exp_count(7));
        @(posedge r_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rptr", int'(rptr), 0);
        chk("async_raddr", int'(raddr), 0);
        chk("async_empty", int'(empty), 1);
        chk("async_count", int'(rd_count), 0);
        chk("async_ae", int'(almost_empty), 1);
        do_reset();

        // Randomized reads and write-pointer advances.
        for (int i = 0; i < 3000; i++) begin
            @(negedge r_clk);
            r_en = 1'($urandom % 2);
            if (($urandom % 3) == 0) begin
                int step;
                step = int'($urandom_range(0, 3));
                if (wbin + step - m_rd <= DEPTH) wbin = wbin + step;
            end
            if (i == 1500) begin
                do_reset();
            end
        end
        r_en = 1'b0;
        repeat (3) @(negedge r_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
